// File: rtl/quad_enc_emulator.sv
// Quadrature encoder emulator: turns commanded relative moves into 4X A/B/I
// waveforms, one edge every 'per' sclk cycles, tracking an emulated position.
// Build option: define QENC_EMU_INDEX_EN to drive enc_i high while
// position == 0; otherwise enc_i is tied low.
module quad_enc_emulator #(
    parameter int ENC_CYCLES_PER_REV = 2048,
    parameter int ENC_COUNTS_PER_REV = ENC_CYCLES_PER_REV * 4,
    parameter int ENC_COUNT_SIZE     = $clog2(ENC_COUNTS_PER_REV),
    parameter int STEPS_W            = 16,
    parameter int PERIOD_W           = 24,
    parameter int MIN_PERIOD         = 4
) (
    input  logic                        sclk,
    input  logic                        rstn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic signed [STEPS_W-1:0]   cmd_steps,
    input  logic [PERIOD_W-1:0]         cmd_period,
    input  logic                        abort,
    input  logic                        home,
    output logic                        enc_a,
    output logic                        enc_b,
    output logic                        enc_i,
    output logic [ENC_COUNT_SIZE-1:0]   position,
    output logic                        busy,
    output logic                        done
);

    localparam logic [ENC_COUNT_SIZE-1:0] CNT_MAX = ENC_COUNT_SIZE'(ENC_COUNTS_PER_REV - 1);
    localparam logic [PERIOD_W-1:0]       MIN_PER = PERIOD_W'(MIN_PERIOD);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                     state_reg;
    logic [STEPS_W-1:0]         remaining_reg;
    logic                       dir_reg;        // 1 = reverse
    logic [PERIOD_W-1:0]        per_reg;
    logic [PERIOD_W-1:0]        timer_reg;
    logic [ENC_COUNT_SIZE-1:0]  position_reg;
    logic                       enc_a_reg;
    logic                       enc_b_reg;
    logic                       cmd_ready_reg;
    logic                       busy_reg;
    logic                       done_reg;

    logic [ENC_COUNT_SIZE-1:0]  pos_fwd;
    logic [ENC_COUNT_SIZE-1:0]  pos_rev;
    logic [ENC_COUNT_SIZE-1:0]  pos_next;
    logic [STEPS_W-1:0]         steps_abs;
    logic [PERIOD_W-1:0]        per_clamped;
    logic                       edge_now;
    logic                       last_edge;

    // Magnitude as unsigned so the most negative move length is still legal;
    // periods below the minimum are raised so a downstream synchronizer
    // never loses an edge.
    assign steps_abs   = cmd_steps[STEPS_W-1] ? (~$unsigned(cmd_steps) + 1'b1)
                                              : $unsigned(cmd_steps);
    assign per_clamped = (cmd_period < MIN_PER) ? MIN_PER : cmd_period;

    // Wrapping neighbours of the current position.
    assign pos_fwd = (position_reg == CNT_MAX) ? '0 : position_reg + 1'b1;
    assign pos_rev = (position_reg == '0) ? CNT_MAX : position_reg - 1'b1;

    // Next position: home in IDLE, one edge per timer expiry in RUN (abort wins).
    always_comb begin
        pos_next  = position_reg;
        edge_now  = 1'b0;
        last_edge = 1'b0;
        case (state_reg)
            IDLE: begin
                if (home) begin
                    pos_next = '0;
                end
            end
            RUN: begin
                if (!abort && (timer_reg == '0)) begin
                    edge_now = 1'b1;
                    pos_next = dir_reg ? pos_rev : pos_fwd;
                end
            end
            default: ;
        endcase
        last_edge = edge_now && (remaining_reg == STEPS_W'(1));
    end

    // Move FSM plus registered pin/status outputs; A/B derive from the next
    // position so pins and position change on the same edge.
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            dir_reg       <= 1'b0;
            per_reg       <= MIN_PER;
            timer_reg     <= '0;
            position_reg  <= '0;
            enc_a_reg     <= 1'b0;
            enc_b_reg     <= 1'b0;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            position_reg <= pos_next;
            enc_a_reg    <= pos_next[1] ^ pos_next[0];
            enc_b_reg    <= pos_next[1];
            done_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    if (cmd_valid && cmd_ready_reg) begin
                        if (cmd_steps == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            remaining_reg <= steps_abs;
                            dir_reg       <= cmd_steps[STEPS_W-1];
                            per_reg       <= per_clamped;
                            timer_reg     <= per_clamped - 1'b1;
                            state_reg     <= RUN;
                            cmd_ready_reg <= 1'b0;
                            busy_reg      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_reg     <= IDLE;
                        cmd_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end else if (edge_now) begin
                        remaining_reg <= remaining_reg - 1'b1;
                        timer_reg     <= per_reg - 1'b1;
                        if (last_edge) begin
                            // ready re-asserts one cycle after done
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef QENC_EMU_INDEX_EN
    logic enc_i_reg;

    // Index is high for the single count at position 0, aligned with A/B.
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            enc_i_reg <= 1'b1;
        end else begin
            enc_i_reg <= (pos_next == '0);
        end
    end

    assign enc_i = enc_i_reg;
`else
    assign enc_i = 1'b0;
`endif

    assign enc_a     = enc_a_reg;
    assign enc_b     = enc_b_reg;
    assign position  = position_reg;
    assign cmd_ready = cmd_ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: doc/quad_enc_emulator.md
Name: quad_enc_emulator

Overview:
Synthesizable quadrature encoder emulator: generates A/B/I waveforms from commanded relative moves. Used for hardware-in-the-loop bring-up of the rover motor-control path without a physical motor. Drives pins in the same 4X format the decoder consumes, so the decoder's count must track emulator position exactly. One move is accepted per valid/ready handshake.

Parameters:
ENC_CYCLES_PER_REV, 2048, quadrature cycles per revolution
ENC_COUNTS_PER_REV, ENC_CYCLES_PER_REV*4, edges per revolution
ENC_COUNT_SIZE, $clog2(ENC_COUNTS_PER_REV), position width
STEPS_W, 16, signed move-length width
PERIOD_W, 24, edge-period width in sclk cycles
MIN_PERIOD, 4, minimum edge spacing (clamps cmd_period; must be >=4 so a 3-flop synchronizer never misses an edge)

Ports:
sclk  in  1  system clock
rstn  in  1  synchronous active-low reset
cmd_valid  in  1  move request
cmd_ready  out  1  high in IDLE only
cmd_steps  in  STEPS_W  signed edge count; +: forward, -: reverse
cmd_period  in  PERIOD_W  sclk cycles between edges
abort  in  1  terminate move in progress
home  in  1  zero position (IDLE only)
enc_a  out  1  channel A
enc_b  out  1  channel B
enc_i  out  1  index
position  out  ENC_COUNT_SIZE  current emulated count
busy  out  1  high in RUN
done  out  1  one-cycle pulse at normal move completion

Behaviour:
- Reset is synchronous, active-low, clock sclk. Reset values: position=0, enc_a=0, enc_b=0, enc_i per optional feature, cmd_ready=1, busy=0, done=0, FSM=IDLE.
- All outputs are registered.
- Phase equals position[1:0]. (A,B) = 00, 10, 11, 01 for phase 0..3.
- Forward edge: position+1, wrapping ENC_COUNTS_PER_REV-1 -> 0. Reverse edge: position-1, wrapping 0 -> ENC_COUNTS_PER_REV-1.
- Exactly one of A/B toggles per edge. Never zero or two toggles.
- FSM IDLE:
  - cmd_ready=1.
  - On cmd_valid with cmd_steps==0: done pulses on the next cycle; FSM stays IDLE.
  - On cmd_valid with cmd_steps!=0: latch remaining=|cmd_steps| as STEPS_W-bit unsigned (-2^(STEPS_W-1) is legal); latch dir=sign; latch per=max(cmd_period, MIN_PERIOD); timer=per-1; go RUN.
  - home pulse in IDLE: position<=0 next cycle.
  - cmd_valid and home together in IDLE: home applies first; the move starts from 0.
- FSM RUN:
  - cmd_ready=0, busy=1. home is ignored.
  - Timer decrements each cycle. At timer==0: apply one edge, remaining-1, timer<=per-1.
  - First edge is visible on outputs exactly per cycles after the accept cycle. Subsequent edges are spaced exactly per cycles.
  - When the final edge is applied: go IDLE; done=1 in the same cycle the final edge appears on the outputs; cmd_ready=1 on the following cycle.
- abort in RUN: go IDLE next cycle. No further edges. No done pulse. Outputs hold their current levels. If abort coincides with timer==0, that edge is suppressed.
- abort in IDLE: no effect.
- Reset mid-move: immediate return to reset values. An A/B jump to 00 is permitted.
- cmd_steps/cmd_period are sampled only at the accept cycle. Changes during RUN are ignored.

Optional Feature:
QENC_EMU_INDEX_EN
- Defined: enc_i=1 when position==0 (one count wide, phase 00), otherwise 0. Reset value 1. Registered with A/B so it aligns with the edge producing position 0.
- Undefined: enc_i tied 0 (reset value 0); no index compare logic.

Test Plan:
- Reset: hold rstn=0 for 3 cycles -> enc_a=0, enc_b=0, position=0, cmd_ready=1, busy=0; enc_i=1 (macro on) / 0 (off).
- From position 0, steps=+4, period=10 -> edges at cycles 10,20,30,40 after accept; AB=10,11,01,00; position 1,2,3,4; done single pulse at cycle 40; cmd_ready back at 41.
- From position 0, steps=-1, period=4 -> AB=01; position=8191; enc_i falls 1->0 (macro on). Then steps=+1 -> position 0, AB=00, enc_i=1.
- period=0 and period=1 -> clamped; measured edge spacing 4 cycles. steps=0 -> done next cycle, busy never asserts.
- steps=+100, period=6; assert abort after the 37th edge, coincident with timer==0 -> position stays 37; no 38th edge; no done; cmd_ready=1 next cycle. Then home -> position 0.
- Loopback into the encoder decoder: steps=+5000 then -7000, period=4 -> decoder count equals emulator position (8192-2000=6192) after each move; no illegal AB transitions flagged by the assertion monitor.
